instr_prefetch: RTL and testbench

- Parametrised successor to the single-register PC fetch stage: generates fetch addresses, issues them over a valid/ready instruction-memory request channel, and buffers in-order responses in a DEPTH-entry prefetch queue.
- Presents {instr_pc, instr_data} to decode over a valid/ready handshake.
- Sits between the PC/branch logic and decode.
- On a branch, flushes the queue and discards stale in-flight responses.

---
 rtl/instr_prefetch_if.sv | 24 ++
 rtl/instr_prefetch.sv | 124 ++++++++++++
 tb/tb_instr_prefetch.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_if.sv
// Instruction-fetch bus: memory request/response channel plus the decode-side handshake.
interface instr_prefetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );
endinterface

// File: rtl/instr_prefetch.sv
// Prefetching fetch stage: credit-limited request issue, PC tag FIFO and DEPTH-entry queue.
// Optional macro IF_PERF_CNT_EN adds saturating flush/stall performance counters.
module instr_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     PC_INC   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       halt,
    input  logic                       branch_en,
    input  logic [XLEN-1:0]            branch_addr,
    output logic                       branch_taken,
    instr_prefetch_if.master           bus,
    output logic [$clog2(DEPTH):0]     q_count
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                perf_flush_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {FETCH, HALTED} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [AW-1:0]   tag_wptr, tag_rptr, q_wptr, q_rptr;
    logic [XLEN-1:0] tag_mem  [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic credit_ok, req_valid, accept, rsp, drop, push, pop, head_valid;

    // Credit covers both buffered entries and every in-flight fetch, including ones to be dropped.
    assign credit_ok  = ({1'b0, outstanding} + {1'b0, q_count}) < (CW + 1)'(DEPTH);
    assign req_valid  = rst_n & (state == FETCH) & ~halt & credit_ok & ~branch_en;
    assign accept     = req_valid & bus.imem_req_ready;
    assign rsp        = bus.imem_rsp_valid;
    assign drop       = rsp & (drop_cnt != '0);
    assign push       = rsp & ~drop & ~branch_en;
    assign head_valid = (q_count != '0);
    assign pop        = head_valid & bus.instr_ready & ~branch_en;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = head_valid;
    assign bus.instr_pc       = head_valid ? pc_mem[q_rptr]   : '0;
    assign bus.instr_data     = head_valid ? data_mem[q_rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            branch_taken <= 1'b0;
            fetch_pc     <= RESET_PC;
            outstanding  <= '0;
            drop_cnt     <= '0;
            q_count      <= '0;
            tag_wptr     <= '0;
            tag_rptr     <= '0;
            q_wptr       <= '0;
            q_rptr       <= '0;
        end else begin
            state        <= halt ? HALTED : FETCH;
            branch_taken <= branch_en;
            outstanding  <= outstanding + CW'(accept) - CW'(rsp);
            if (branch_en) begin
                // Everything still in flight becomes stale; a response this cycle is already gone.
                fetch_pc <= branch_addr;
                drop_cnt <= outstanding - CW'(rsp);
                q_count  <= '0;
                tag_wptr <= '0;
                tag_rptr <= '0;
                q_wptr   <= '0;
                q_rptr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(PC_INC);
                    tag_wptr <= tag_wptr + 1'b1;
                end
                if (drop)
                    drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    tag_rptr <= tag_rptr + 1'b1;
                    q_wptr   <= q_wptr + 1'b1;
                end
                if (pop)
                    q_rptr <= q_rptr + 1'b1;
                q_count <= q_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_mem[tag_wptr] <= fetch_pc;
        if (push) begin
            pc_mem[q_wptr]   <= tag_mem[tag_rptr];
            data_mem[q_wptr] <= bus.imem_rsp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic stall;
    assign stall = (state == FETCH) & ~halt & (~req_valid | ~bus.imem_req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (branch_en && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            if (stall && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with an in-order, fixed-latency memory model.
module tb_instr_prefetch;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] MAGIC = 32'hC0DE_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } deliv_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        branch_en;
    logic [31:0] branch_addr;
    logic        branch_taken;
    logic [2:0]  q_count;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    int acc_cnt = 0;
    pend_t  pend[$];
    deliv_t got[$];

    instr_prefetch_if #(.XLEN(XLEN)) bus ();

    instr_prefetch #(
        .XLEN     (XLEN),
        .PC_INC   (4),
        .RESET_PC (32'h0),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt           (halt),
        .branch_en      (branch_en),
        .branch_addr    (branch_addr),
        .branch_taken   (branch_taken),
        .bus            (bus.master),
        .q_count        (q_count)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy, input int l);
        rst_n           = 1'b0;
        halt            = 1'b0;
        branch_en       = 1'b0;
        branch_addr     = '0;
        bus.instr_ready = rdy;
        lat             = l;
        got.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Memory: samples acceptance mid-cycle, answers in order after lat cycles.
    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                acc_cnt = 0;
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
                acc_cnt++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = pend[0].addr ^ MAGIC;
                void'(pend.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !branch_en && bus.instr_valid && bus.instr_ready)
                got.push_back('{pc: bus.instr_pc, data: bus.instr_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; halt = 1'b0; branch_en = 1'b0; branch_addr = '0;
        bus.instr_ready = 1'b1;
        #3;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_q_count", q_count, 0);
        check("rst_branch_taken", branch_taken, 0);

        // Streaming with 1-cycle latency: 2-cycle fill then one per cycle.
        do_reset(1'b1, 1);
        @(negedge clk);
        check("t1_req_valid", bus.imem_req_valid, 1);
        check("t1_req_addr", bus.imem_req_addr, 32'h0);
        @(negedge clk);
        check("t1_fill_empty", bus.instr_valid, 0);
        @(negedge clk);
        check("t1_first_valid", bus.instr_valid, 1);
        check("t1_first_pc", bus.instr_pc, 32'h0);
        check("t1_first_data", bus.instr_data, 32'hC0DE_0000);
        repeat (7) @(negedge clk);
        tick();
        check("t1_count", got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (got.size() > i) check("t1_pc", got[i].pc, 32'(i * 4));
        if (got.size() > 5) check("t1_data5", got[5].data, 32'hC0DE_0014);

        // Credit limit with decode stalled.
        do_reset(1'b0, 1);
        repeat (8) tick();
        check("t2_acc", acc_cnt, 4);
        @(negedge clk);
        check("t2_q_full", q_count, 4);
        check("t2_req_blocked", bus.imem_req_valid, 0);
        tick();
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        @(negedge clk);
        check("t2_q_after_pop", q_count, 3);
        check("t2_req_resume", bus.imem_req_valid, 1);
        check("t2_req_addr", bus.imem_req_addr, 32'h10);
        tick();
        check("t2_acc5", acc_cnt, 5);
        check("t2_popped_pc", got.size() > 0 ? got[0].pc : 32'hDEAD_BEEF, 32'h0);

        // Redirect with three requests in flight.
        do_reset(1'b1, 10);
        repeat (3) tick();
        branch_en   = 1'b1;
        branch_addr = 32'h100;
        @(negedge clk);
        check("t3_req_withdrawn", bus.imem_req_valid, 0);
        tick();
        branch_en = 1'b0;
        check("t3_inflight", acc_cnt, 3);
        @(negedge clk);
        check("t3_taken", branch_taken, 1);
        check("t3_req_addr", bus.imem_req_addr, 32'h100);
        tick();
        @(negedge clk);
        check("t3_taken_pulse", branch_taken, 0);
        for (int i = 0; i < 80; i++) begin
            if (got.size() >= 2) break;
            tick();
        end
        check("t3_delivered", got.size() >= 2, 1);
        if (got.size() >= 2) begin
            check("t3_pc0", got[0].pc, 32'h100);
            check("t3_data0", got[0].data, 32'hC0DE_0100);
            check("t3_pc1", got[1].pc, 32'h104);
        end
`ifdef IF_PERF_CNT_EN
        check("t3_flush_cnt", perf_flush_cnt, 1);
`endif

        // Halt with two responses pending.
        do_reset(1'b1, 3);
        repeat (2) tick();
        halt = 1'b1;
        @(negedge clk);
        check("t4_req_halted", bus.imem_req_valid, 0);
        repeat (8) tick();
        check("t4_acc", acc_cnt, 2);
        check("t4_drained", got.size(), 2);
        if (got.size() >= 2) begin
            check("t4_pc0", got[0].pc, 32'h0);
            check("t4_pc1", got[1].pc, 32'h4);
        end
        check("t4_q_empty", q_count, 0);
        halt = 1'b0;
        tick();
        @(negedge clk);
        check("t4_resume_valid", bus.imem_req_valid, 1);
        check("t4_resume_addr", bus.imem_req_addr, 32'h8);

        // Address wrap after redirect to the top of the space.
        do_reset(1'b1, 1);
        branch_en   = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        tick();
        branch_en = 1'b0;
        repeat (6) tick();
        check("t5_count", got.size() >= 2, 1);
        if (got.size() >= 2) begin
            check("t5_pc0", got[0].pc, 32'hFFFF_FFFC);
            check("t5_data0", got[0].data, 32'h3F21_FFFC);
            check("t5_pc1", got[1].pc, 32'h0);
            check("t5_data1", got[1].data, 32'hC0DE_0000);
        end

        // Asynchronous reset with a full queue.
        do_reset(1'b0, 1);
        repeat (8) tick();
        check("t6_full", q_count, 4);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_q_cleared", q_count, 0);
        check("t6_instr_valid", bus.instr_valid, 0);
        check("t6_instr_pc", bus.instr_pc, 32'h0);
        check("t6_req_valid", bus.imem_req_valid, 0);
        check("t6_req_addr", bus.imem_req_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("t6_flush_cnt", perf_flush_cnt, 0);
        check("t6_stall_cnt", perf_stall_cnt, 0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_valid", bus.imem_req_valid, 1);
        check("t6_post_addr", bus.imem_req_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
